// File: rtl/calc_display_driver.sv
// calc_display_driver
//
// Converts an 8-bit unsigned value to three BCD digits with a serial
// double-dabble engine. It also scans the last completed result onto a
// multiplexed three-digit seven-segment display.
//
// Ports
//   clock    : system clock, all state changes on the rising edge
//   Reset    : synchronous, active-high reset
//   NumIn    : 8-bit unsigned value to convert
//   Load     : conversion request, sampled on the clock edge
//   Busy     : high while a conversion is in progress
//   Done     : one-cycle pulse when BcdOut has been updated
//   BcdOut   : last completed result, {hundreds, tens, ones}
//   Segments : active-high segments, bit0 = a .. bit6 = g
//   DigitSel : one-hot digit enable, bit0 = ones, bit1 = tens, bit2 = hundreds
//   DbgState : conversion FSM state (0 = IDLE, 1 = SHIFT)
//
// Handshake: Load is a request, not a valid/ready pair. The FSM accepts
// Load only in IDLE, which covers the cycle in which Done is high. A Load
// seen while Busy is high is dropped and is not queued.
module calc_display_driver #(
    parameter int unsigned REFRESH_DIV = 1024
) (
    input  logic        clock,
    input  logic        Reset,
    input  logic [7:0]  NumIn,
    input  logic        Load,
    output logic        Busy,
    output logic        Done,
    output logic [11:0] BcdOut,
    output logic [6:0]  Segments,
    output logic [2:0]  DigitSel,
    output logic        DbgState
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] REF_MAX = CW'(REFRESH_DIV - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t      state_q;
    logic [7:0]  bin_q;
    logic [11:0] bcd_q;
    logic [2:0]  cnt_q;
    logic        done_q;
    logic [11:0] bcd_out_q;

    logic [11:0] bcd_adj;
    logic [11:0] bcd_d;
    logic [7:0]  bin_d;

    logic [CW-1:0] ref_q;
    logic [1:0]    idx_q;

    // One double-dabble step: correct each nibble that is >= 5, then shift
    // {bcd, bin} left by one bit.
    always_comb begin
        bcd_adj = bcd_q;
        if (bcd_q[3:0]  >= 4'd5) bcd_adj[3:0]  = bcd_q[3:0]  + 4'd3;
        if (bcd_q[7:4]  >= 4'd5) bcd_adj[7:4]  = bcd_q[7:4]  + 4'd3;
        if (bcd_q[11:8] >= 4'd5) bcd_adj[11:8] = bcd_q[11:8] + 4'd3;
        bcd_d = {bcd_adj[10:0], bin_q[7]};
        bin_d = {bin_q[6:0], 1'b0};
    end

    always_ff @(posedge clock) begin
        if (Reset) begin
            state_q   <= IDLE;
            bin_q     <= 8'd0;
            bcd_q     <= 12'd0;
            cnt_q     <= 3'd0;
            done_q    <= 1'b0;
            bcd_out_q <= 12'd0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (Load) begin
                        bin_q   <= NumIn;
                        bcd_q   <= 12'd0;
                        cnt_q   <= 3'd0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    bin_q <= bin_d;
                    bcd_q <= bcd_d;
                    cnt_q <= cnt_q + 3'd1;
                    // The eighth step completes here. Publish its result
                    // directly so BcdOut never shows partial values.
                    if (cnt_q == 3'd7) begin
                        bcd_out_q <= bcd_d;
                        done_q    <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Busy     = (state_q == SHIFT);
    assign Done     = done_q;
    assign BcdOut   = bcd_out_q;
    assign DbgState = state_q;

    // Display scan: the refresh counter runs freely, and the digit index
    // advances once per wrap in the order ones -> tens -> hundreds.
    always_ff @(posedge clock) begin
        if (Reset) begin
            ref_q <= '0;
            idx_q <= 2'd0;
        end else if (ref_q == REF_MAX) begin
            ref_q <= '0;
            idx_q <= (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
        end else begin
            ref_q <= ref_q + CW'(1);
        end
    end

    always_comb begin
        case (idx_q)
            2'd1:    DigitSel = 3'b010;
            2'd2:    DigitSel = 3'b100;
            default: DigitSel = 3'b001;
        endcase
    end

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        case (nib)
            4'd0:    seg_decode = 7'h3F;
            4'd1:    seg_decode = 7'h06;
            4'd2:    seg_decode = 7'h5B;
            4'd3:    seg_decode = 7'h4F;
            4'd4:    seg_decode = 7'h66;
            4'd5:    seg_decode = 7'h6D;
            4'd6:    seg_decode = 7'h7D;
            4'd7:    seg_decode = 7'h07;
            4'd8:    seg_decode = 7'h7F;
            4'd9:    seg_decode = 7'h6F;
            default: seg_decode = 7'h00;
        endcase
    endfunction

    // The segment decode reads BcdOut directly. A new result therefore
    // appears on the selected digit in the same cycle it is loaded.
    // Leading zeros are blanked. The ones digit is never blanked.
    logic [3:0] nib_sel;
    logic       blank;

    always_comb begin
        nib_sel = bcd_out_q[3:0];
        blank   = 1'b0;
        case (idx_q)
            2'd1: begin
                nib_sel = bcd_out_q[7:4];
                blank   = (bcd_out_q[11:8] == 4'd0) && (bcd_out_q[7:4] == 4'd0);
            end
            2'd2: begin
                nib_sel = bcd_out_q[11:8];
                blank   = (bcd_out_q[11:8] == 4'd0);
            end
            default: begin
                nib_sel = bcd_out_q[3:0];
                blank   = 1'b0;
            end
        endcase
        Segments = blank ? 7'h00 : seg_decode(nib_sel);
    end

endmodule

// File: doc/calc_display_driver.md
CALC_DISPLAY_DRIVER -- requirements
Module: calc_display_driver

Parameters
REQ-001 The block SHALL have parameter REFRESH_DIV, default 1024: clock cycles per displayed digit; the legal range is 2..65536.

Interface
REQ-002 The block SHALL have port clock  input  1  system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port NumIn  input  8  unsigned accumulator value from the calculator datapath.
REQ-005 The block SHALL have port Load  input  1  request to convert NumIn, sampled on the clock edge.
REQ-006 The block SHALL have port Busy  output  1  high while a conversion is in progress.
REQ-007 The block SHALL have port Done  output  1  single-cycle pulse when BcdOut has been updated.
REQ-008 The block SHALL have port BcdOut  output  12  packed as hundreds[11:8], tens[7:4], ones[3:0]; it holds the last completed result.
REQ-009 The block SHALL have port Segments  output  7  active-high segments, bit0=a through bit6=g.
REQ-010 The block SHALL have port DigitSel  output  3  one-hot, active-high digit enable: bit0=ones, bit1=tens, bit2=hundreds.

Function -- conversion
REQ-011 The conversion FSM SHALL have the states IDLE and SHIFT.
REQ-012 In IDLE, Load=1 at edge k SHALL capture NumIn, clear the BCD scratch register, set the iteration count to 0 and enter SHIFT.
REQ-013 In SHIFT, edges k+1..k+8 SHALL each perform one double-dabble iteration: add 3 to each BCD nibble that is >=5, then shift {BCD, binary} left by 1.
REQ-014 At edge k+8 the block SHALL load BcdOut with the final BCD value, assert Done for exactly one cycle, deassert Busy and return to IDLE.
REQ-015 Busy SHALL be 1 in the cycles after edges k through k+7, and 0 otherwise.
REQ-016 Load while Busy=1 SHALL be ignored: no restart and no queuing.
REQ-017 Load sampled in the cycle where Done=1 SHALL be accepted, because the FSM is already in IDLE.
REQ-018 BcdOut SHALL change only at the completion edge and SHALL never show intermediate values.
REQ-019 Every 8-bit input (0..255) SHALL convert exactly, with no overflow, since 255 fits in three BCD digits.

Function -- display scan
REQ-020 A refresh counter SHALL count 0..REFRESH_DIV-1 and wrap; on wrap, the digit index SHALL advance ones -> tens -> hundreds -> ones.
REQ-021 DigitSel SHALL be the one-hot decode of the digit index, and exactly one bit SHALL be high at all times after reset.
REQ-022 Segments SHALL be the combinational decode of the selected BcdOut nibble: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F (hex).
REQ-023 Nibble values 10..15 cannot occur; if present, the decode SHALL output 00.
REQ-024 Leading-zero blanking: with hundreds=0, the hundreds digit SHALL show Segments=00.
REQ-025 Leading-zero blanking: with hundreds=0 and tens=0, the tens digit SHALL show Segments=00.
REQ-026 The ones digit SHALL never be blanked.
REQ-027 The scan SHALL run continuously, independent of conversion; a BcdOut update SHALL be reflected on the currently selected digit in the same cycle.

Reset
REQ-028 Reset=1 at an edge SHALL force: FSM=IDLE, Busy=0, Done=0, BcdOut=000, refresh counter=0, digit index=ones.
REQ-029 Immediately after reset, DigitSel SHALL be 001 and Segments SHALL be 3F.
REQ-030 Reset during SHIFT SHALL abort the conversion with no Done pulse, and BcdOut SHALL be 000.
REQ-031 Reset SHALL take priority over Load in the same cycle.
REQ-032 Reset SHALL act only on the rising edge of clock.

Verification
REQ-033 Scenario (latency): Load=1 with NumIn=255 at edge k -> Busy=1 for 8 cycles; Done pulses after edge k+8; BcdOut=0x255.
REQ-034 Scenario (blanking): convert 7, REFRESH_DIV=4 -> ones digit Segments=07, tens=00, hundreds=00.
REQ-035 Scenario (internal zero): convert 105 -> BcdOut=0x105; tens digit shows 3F (not blanked); hundreds shows 06.
REQ-036 Scenario (ignored Load): convert 200; pulse Load with NumIn=99 at edge k+3 -> result 0x200, one Done pulse only; a Load on the Done cycle with NumIn=99 -> result 0x099.
REQ-037 Scenario (reset mid-conversion): Reset at edge k+4 -> Busy=0, no Done, BcdOut=000, DigitSel=001, Segments=3F.
REQ-038 Scenario (scan): REFRESH_DIV=4, from reset -> DigitSel 001 for 4 cycles, 010 for 4 cycles, 100 for 4 cycles, then 001; the bench SHALL also check all 256 inputs against a decimal model.
